// File: rtl/controller_kes.sv
// rtl/controller_kes.sv - Berlekamp-Massey KES stage sequencer with pending-start buffer and ready-gated done
module controller_kes #(
    parameter int ITER_NUM       = 8,
    parameter int ITER_CLK_CYCLE = 3,
    parameter int ITER_BIT_LEN   = 4,
    parameter int STEP_BIT_LEN   = 2
) (
    input  logic                    clk,
    input  logic                    in_ctr_Arst_n,
    input  logic                    in_ctr_en,
    input  logic                    in_ctr_start,
    input  logic                    in_ctr_back_rdy,
    output logic                    out_ctr_kes_init,
    output logic                    out_ctr_kes_proc_en,
    output logic                    out_ctr_kes_en,
    output logic [ITER_BIT_LEN-1:0] out_ctr_kes_iter_cnt,
    output logic [STEP_BIT_LEN-1:0] out_ctr_kes_step_cnt,
    output logic                    out_ctr_kes_iter_last,
    output logic                    out_ctr_done,
    output logic                    out_ctr_busy,
    output logic                    out_ctr_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [ITER_BIT_LEN-1:0] ITER_LAST = ITER_BIT_LEN'(ITER_NUM - 1);
    localparam logic [STEP_BIT_LEN-1:0] STEP_LAST = STEP_BIT_LEN'(ITER_CLK_CYCLE - 1);

    state_t                  state;
    logic [ITER_BIT_LEN-1:0] iter_cnt;
    logic [STEP_BIT_LEN-1:0] step_cnt;
    logic                    pending;
    logic                    overrun;
    logic                    final_step;
    logic                    complete;

    assign final_step = (state == S_RUN) && (iter_cnt == ITER_LAST) && (step_cnt == STEP_LAST);
    // A result is handed off only when the back end is ready, either straight from RUN or out of HOLD.
    assign complete   = in_ctr_en && in_ctr_back_rdy && (final_step || (state == S_HOLD));

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            step_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else if (in_ctr_en) begin
            case (state)
                S_IDLE: begin
                    if (in_ctr_start) begin
                        state <= S_INIT;
                    end else if (pending) begin
                        state   <= S_INIT;
                        pending <= 1'b0;
                    end
                end
                S_INIT: begin
                    iter_cnt <= '0;
                    step_cnt <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (final_step) begin
                        if (!in_ctr_back_rdy) begin
                            state <= S_HOLD;
                        end
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        iter_cnt <= iter_cnt + 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            // Completion overrides the case above; a start arriving on that same cycle chains the next codeword.
            if (complete) begin
                state   <= (pending || in_ctr_start) ? S_INIT : S_IDLE;
                pending <= pending && in_ctr_start;
            end else if (in_ctr_start && (state != S_IDLE)) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    assign out_ctr_kes_init      = in_ctr_en && (state == S_INIT);
    assign out_ctr_kes_proc_en   = (state == S_RUN) || (state == S_HOLD);
    assign out_ctr_kes_en        = in_ctr_en && (state == S_RUN);
    assign out_ctr_kes_iter_cnt  = iter_cnt;
    assign out_ctr_kes_step_cnt  = step_cnt;
    assign out_ctr_kes_iter_last = (state == S_RUN) && (iter_cnt == ITER_LAST);
    assign out_ctr_done          = complete;
    assign out_ctr_busy          = (state != S_IDLE);
    assign out_ctr_overrun       = overrun;

endmodule

// File: tb/tb_controller_kes.sv
// tb/tb_controller_kes.sv - table-driven bench for controller_kes
module tb_controller_kes;

    localparam int NC = 64;
    localparam int SIG_INIT = 0, SIG_KESEN = 1, SIG_DONE = 2, SIG_BUSY = 3;
    localparam int SIG_PROC = 4, SIG_LAST = 5, SIG_OVR = 6, SIG_ITER = 7, SIG_STEP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       rdy = 1'b1;
    logic       kes_init, proc_en, kes_en, iter_last, done, busy, overrun;
    logic [3:0] iter_cnt;
    logic [1:0] step_cnt;

    controller_kes dut (
        .clk                  (clk),
        .in_ctr_Arst_n        (rst_n),
        .in_ctr_en            (en),
        .in_ctr_start         (start),
        .in_ctr_back_rdy      (rdy),
        .out_ctr_kes_init     (kes_init),
        .out_ctr_kes_proc_en  (proc_en),
        .out_ctr_kes_en       (kes_en),
        .out_ctr_kes_iter_cnt (iter_cnt),
        .out_ctr_kes_step_cnt (step_cnt),
        .out_ctr_kes_iter_last(iter_last),
        .out_ctr_done         (done),
        .out_ctr_busy         (busy),
        .out_ctr_overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    scen;
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [6:0] tr_bits [NC];
    int         tr_iter [NC];
    int         tr_step [NC];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sample(input int sig, input int c);
        if (sig == SIG_ITER) return tr_iter[c];
        if (sig == SIG_STEP) return tr_step[c];
        return int'(tr_bits[c][sig]);
    endfunction

    function automatic int count_sig(input int sig, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += sample(sig, c);
        return n;
    endfunction

    function automatic logic start_at(input int s, input int c);
        case (s)
            3:       return (c == 0) || (c == 12);
            4:       return (c == 5) || (c == 8) || (c == 11);
            5:       return (c == 0) || (c == 20);
            default: return (c == 0);
        endcase
    endfunction

    task automatic add(input int s, input int c, input int sig, input int e, input string n);
        vec_t v;
        v.scen = s; v.cyc = c; v.sig = sig; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; en = 1'b1; rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_scen(input int s);
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            start = start_at(s, c);
            rdy   = !(s == 1 && c >= 20 && c <= 29);
            en    = !(s == 2 && c >= 10 && c <= 14);
            rst_n = !(s == 5 && c >= 16 && c <= 18);
            #1;
            tr_bits[c] = {overrun, iter_last, proc_en, busy, done, kes_en, kes_init};
            tr_iter[c] = int'(iter_cnt);
            tr_step[c] = int'(step_cnt);
            if (s == 5 && c == 15) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_mid_busy", int'(busy), 0);
                check("rst_mid_kes_en", int'(kes_en), 0);
                check("rst_mid_proc_en", int'(proc_en), 0);
                check("rst_mid_iter", int'(iter_cnt), 0);
                check("rst_mid_step", int'(step_cnt), 0);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // basic
        add(0, 0, SIG_INIT, 0, "basic_init_c0");
        add(0, 1, SIG_INIT, 1, "basic_init_c1");
        add(0, 1, SIG_PROC, 0, "basic_proc_c1");
        add(0, 2, SIG_KESEN, 1, "basic_kes_en_c2");
        add(0, 2, SIG_PROC, 1, "basic_proc_c2");
        add(0, 25, SIG_KESEN, 1, "basic_kes_en_c25");
        add(0, 26, SIG_KESEN, 0, "basic_kes_en_c26");
        add(0, 22, SIG_LAST, 0, "basic_last_c22");
        add(0, 23, SIG_LAST, 1, "basic_last_c23");
        add(0, 25, SIG_LAST, 1, "basic_last_c25");
        add(0, 24, SIG_DONE, 0, "basic_done_c24");
        add(0, 25, SIG_DONE, 1, "basic_done_c25");
        add(0, 25, SIG_BUSY, 1, "basic_busy_c25");
        add(0, 26, SIG_BUSY, 0, "basic_busy_c26");
        add(0, 9, SIG_ITER, 2, "basic_iter_c9");
        add(0, 9, SIG_STEP, 1, "basic_step_c9");
        // back-pressure
        add(1, 25, SIG_DONE, 0, "bp_done_c25");
        add(1, 26, SIG_KESEN, 0, "bp_kes_en_c26");
        add(1, 26, SIG_PROC, 1, "bp_proc_c26");
        add(1, 29, SIG_PROC, 1, "bp_proc_c29");
        add(1, 29, SIG_DONE, 0, "bp_done_c29");
        add(1, 30, SIG_DONE, 1, "bp_done_c30");
        add(1, 28, SIG_ITER, 7, "bp_iter_hold");
        add(1, 28, SIG_STEP, 2, "bp_step_hold");
        add(1, 31, SIG_BUSY, 0, "bp_busy_c31");
        // enable stall
        add(2, 10, SIG_ITER, 2, "stall_iter_c10");
        add(2, 10, SIG_STEP, 2, "stall_step_c10");
        add(2, 12, SIG_KESEN, 0, "stall_kes_en_c12");
        add(2, 15, SIG_ITER, 2, "stall_iter_c15");
        add(2, 15, SIG_STEP, 2, "stall_step_c15");
        add(2, 16, SIG_ITER, 3, "stall_iter_c16");
        add(2, 16, SIG_STEP, 0, "stall_step_c16");
        add(2, 25, SIG_DONE, 0, "stall_done_c25");
        add(2, 30, SIG_DONE, 1, "stall_done_c30");
        // back-to-back
        add(3, 25, SIG_DONE, 1, "b2b_done_c25");
        add(3, 25, SIG_INIT, 0, "b2b_init_c25");
        add(3, 26, SIG_INIT, 1, "b2b_init_c26");
        add(3, 50, SIG_DONE, 1, "b2b_done_c50");
        add(3, 51, SIG_BUSY, 0, "b2b_busy_c51");
        // overrun
        add(4, 11, SIG_OVR, 0, "ovr_c11");
        add(4, 12, SIG_OVR, 1, "ovr_c12");
        add(4, 63, SIG_OVR, 1, "ovr_sticky_c63");
        add(4, 30, SIG_DONE, 1, "ovr_done_c30");
        add(4, 31, SIG_INIT, 1, "ovr_init_c31");
        add(4, 55, SIG_DONE, 1, "ovr_done_c55");
        // async reset
        add(5, 15, SIG_BUSY, 1, "arst_busy_c15");
        add(5, 19, SIG_BUSY, 0, "arst_busy_c19");
        add(5, 21, SIG_INIT, 1, "arst_init_c21");
        add(5, 45, SIG_DONE, 1, "arst_done_c45");

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_init", int'(kes_init), 0);
        check("reset_proc_en", int'(proc_en), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_iter", int'(iter_cnt), 0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            run_scen(s);
            foreach (vecs[i]) begin
                if (vecs[i].scen == s)
                    check(vecs[i].name, sample(vecs[i].sig, vecs[i].cyc), vecs[i].exp);
            end
            case (s)
                0: begin
                    check("basic_kes_en_count", count_sig(SIG_KESEN, 0, NC - 1), 24);
                    check("basic_done_count", count_sig(SIG_DONE, 0, NC - 1), 1);
                end
                1: check("bp_hold_cycles", count_sig(SIG_PROC, 26, 30) - count_sig(SIG_KESEN, 26, 30), 5);
                2: check("stall_kes_en_count", count_sig(SIG_KESEN, 0, NC - 1), 24);
                3: check("b2b_done_count", count_sig(SIG_DONE, 0, NC - 1), 2);
                4: check("ovr_done_count", count_sig(SIG_DONE, 0, NC - 1), 2);
                default: begin
                    check("arst_no_done", count_sig(SIG_DONE, 0, 44), 0);
                    check("arst_done_count", count_sig(SIG_DONE, 0, NC - 1), 1);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
